acc_feeder: RTL

Operand sequencer and result collector on the far side of the `accumulator` interface. It accepts a group of `N_TERMS` operands over a valid/ready load port, buffers them, and streams them into the accumulator one per cycle. It then waits for the accumulator's `count_9` completion strobe, captures `acc_out`, and presents the sum on a valid/ready result port. It sits between the upstream data source and `accumulator` in the computation path.

---
 rtl/acc_pkg.sv | 8 +
 rtl/acc_operand_buf.sv | 19 +
 rtl/acc_feeder.sv | 94 +++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared states and default sizing for the accumulator feeder
package acc_pkg;
  typedef enum logic [1:0] {LOAD, FEED, WAIT, HOLD} state_e;
  localparam int ACC_N_TERMS = 9;
  localparam int ACC_DATA_W = 8;
  localparam int ACC_TIMEOUT = 4;
  localparam int ACC_IDX_W = $clog2(ACC_N_TERMS);
endpackage

// File: rtl/acc_operand_buf.sv
// acc_operand_buf: operand register file, one write port and one registered read port
module acc_operand_buf import acc_pkg::*; #(
  parameter int DATA_W = ACC_DATA_W,
  parameter int N_TERMS = ACC_N_TERMS,
  localparam int AW = $clog2(N_TERMS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [N_TERMS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/acc_feeder.sv
// acc_feeder: buffers an operand group, streams it to the accumulator and returns the sum
module acc_feeder import acc_pkg::*; #(
  parameter int DATA_W = ACC_DATA_W,
  parameter int N_TERMS = ACC_N_TERMS,
  parameter int TIMEOUT = ACC_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] acc_in,
  output logic              acc_en,
  input  logic [DATA_W-1:0] acc_out,
  input  logic              count_9,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              err
);
  localparam int IW = $clog2(N_TERMS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(N_TERMS - 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, raddr;
  logic [TW-1:0] timer_q, timer_d;
  logic [DATA_W-1:0] res_data_q, res_data_d, rdata;
  logic in_ready_q, acc_en_q, res_valid_q, err_q, err_d, wr;
  assign wr = state_q == LOAD && in_valid;
  // read one slot ahead so the registered read port lines up with acc_en
  assign raddr = (state_q == FEED && idx_q != LAST) ? idx_q + 1'b1 : '0;
  assign in_ready = in_ready_q;
  assign acc_en = acc_en_q;
  assign acc_in = acc_en_q ? rdata : '0;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign err = err_q;
  acc_operand_buf #(.DATA_W(DATA_W), .N_TERMS(N_TERMS)) u_buf (
    .clk(clk), .we(wr), .waddr(idx_q), .wdata(in_data), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    timer_d = timer_q;
    res_data_d = res_data_q;
    err_d = err_q | (count_9 && state_q != WAIT);
    case (state_q)
      LOAD: if (wr) begin
        idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
        if (idx_q == LAST) state_d = FEED;
      end
      FEED: begin
        idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: if (count_9) begin
        res_data_d = acc_out;
        state_d = HOLD;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        err_d = 1'b1;
        state_d = LOAD;
      end else timer_d = timer_q + 1'b1;
      HOLD: if (res_ready) begin
        state_d = LOAD;
        idx_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      idx_q <= '0;
      timer_q <= '0;
      in_ready_q <= 1'b1;
      acc_en_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
      in_ready_q <= state_d == LOAD;
      acc_en_q <= state_d == FEED;
      res_valid_q <= state_d == HOLD;
      res_data_q <= res_data_d;
      err_q <= err_d;
    end
  end
endmodule
